acl_rxbuf: RTL and testbench
============================

Name: acl_rxbuf

Overview:
- Receive-side ACL-U payload buffer directly upstream of the baseband ARQ / flow-control block.
- Captures decoded payload bytes of the current packet into a slot.
  - Commits the slot when ARQ accepts the payload; discards it on reject, ignore or fail.
- Presents committed packets to the host read port in arrival order.
- Drives aclrxbufempty, which flow control uses to generate the STOP flow bit.

Parameters:
- NSLOT, 2, number of packet slots; power of 2, minimum 2.
- DEPTH, 1024, bytes per slot; power of 2.
- LW, 11, length field width; must hold the value DEPTH.

Ports:
- clk_6M  in  1  system clock.
- rstz  in  1  asynchronous active-low reset.
- wr_start_p  in  1  pulse; a new payload starts, sampled once per received packet.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_data  in  8  payload byte.
- wr_commit_p  in  1  pulse; ARQ accepted the payload (accept_aclpyload).
- wr_discard_p  in  1  pulse; payload rejected, ignored or failed.
- rd_en  in  1  host reads next byte of the head slot.
- rd_pop  in  1  pulse; host releases the head slot.
- rd_data  out  8  registered read byte.
- rd_len  out  LW  byte length of the head slot; 0 when empty.
- aclrxbufempty  out  1  no committed slot pending.
- aclrxbuffull  out  1  all NSLOT slots committed.
- wr_drop_p  out  1  pulse; a packet was lost (buffer full or overflow).

Behaviour:
- Clock and reset: single clock clk_6M; reset rstz is asynchronous and active-low.
- Reset values:
  - Pointers, count and per-slot lengths: 0.
  - rd_data: 0; rd_len: 0.
  - aclrxbufempty: 1; aclrxbuffull: 0; wr_drop_p: 0.
  - Write FSM in IDLE.
- Write FSM, states IDLE, FILL, DROP:
  - IDLE + wr_start_p: go to FILL if not full, else DROP; write byte counter wcnt cleared to 0.
  - FILL + wr_valid: store byte at slot[wptr][wcnt], wcnt++.
    - A wr_valid with wcnt==DEPTH is an overflow: go to DROP, byte not stored.
  - FILL + wr_commit_p: length[wptr] <= wcnt; wptr <= wptr+1 mod NSLOT; count++; go to IDLE.
  - FILL + wr_discard_p: go to IDLE; wptr unchanged, so the slot is reused.
  - DROP + wr_commit_p: wr_drop_p high for 1 cycle; go to IDLE.
  - DROP + wr_discard_p: go to IDLE; no drop pulse, since the packet was not wanted.
  - wr_start_p in FILL or DROP abandons the current packet (treated as discard) and restarts per the IDLE rule in the same cycle.
  - wr_commit_p and wr_discard_p in the same cycle: discard wins.
  - A commit with wcnt==0 is legal: a zero-length slot is stored.
- Read side:
  - rd_en with count>0: rd_data <= slot[rptr][rcnt] on the next clock edge (latency 1); rcnt++.
  - rd_en when rcnt >= rd_len, or when empty: ignored; rd_data holds its value.
  - rd_pop with count>0: rptr <= rptr+1 mod NSLOT; rcnt <= 0; count--.
  - rd_pop when empty: ignored.
  - rd_len is combinational from length[rptr] and is 0 when count==0.
- Simultaneous commit and pop: count unchanged and both pointers advance. A pop while full frees a slot that becomes usable from the next wr_start_p.
- Flags are combinational from count:
  - aclrxbufempty = (count==0).
  - aclrxbuffull = (count==NSLOT).
- Full/empty boundaries:
  - The full check is made only at wr_start_p.
  - A packet in FILL always owns its slot: the slot at wptr is never committed while the FSM is filling it.
- Reset mid-packet: all state returns to reset values; partially written data is lost.

Optional Feature:
- Macro ACLRXBUF_LLID_EN.
- Defined:
  - Adds input wr_llid[1:0], sampled at wr_commit_p into a per-slot register.
  - Adds output rd_llid[1:0] = llid[rptr] (0 when empty), so the host can separate L2CAP start and continuation fragments.
- Undefined: neither port exists and no LLID storage is built.

Test Plan:
- Basic pass-through: wr_start_p, 5 bytes 0x11..0x15, wr_commit_p.
  - Expect aclrxbufempty=0 and rd_len=5.
  - 5 rd_en reads return 0x11..0x15, each one cycle later.
  - rd_pop then gives aclrxbufempty=1 and rd_len=0.
- Discard: 3 bytes then wr_discard_p → aclrxbufempty stays 1. The next packet of 2 bytes (0xA0, 0xA1) with commit reads back 0xA0, 0xA1 from the same slot.
- Full: commit two packets (NSLOT=2) → aclrxbuffull=1.
  - A third wr_start_p, 4 bytes, wr_commit_p → wr_drop_p for 1 cycle; count stays 2.
  - First popped slot holds packet 1's data.
- Overflow: DEPTH=1024, write 1025 bytes then commit → wr_drop_p=1 and aclrxbufempty stays 1.
- Simultaneous: with count=1, wr_commit_p and rd_pop in the same cycle → count stays 1; the new head is the new packet, with rd_len equal to its length.
- ACLRXBUF_LLID_EN defined: commit with wr_llid=2'b10 → rd_llid=2'b10; after pop with the buffer empty → rd_llid=0.

Source files
------------

// File: rtl/acl_rxbuf_if.sv
// Write/read handshake bundle between the ACL-U receive path, acl_rxbuf and the host.
// ACLRXBUF_LLID_EN adds the per-packet LLID in and out.
interface acl_rxbuf_if #(
   parameter int unsigned LW = 11
) ();
   logic          wr_start_p;
   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          wr_commit_p;
   logic          wr_discard_p;
   logic          rd_en;
   logic          rd_pop;
   logic [7:0]    rd_data;
   logic [LW-1:0] rd_len;
   logic          aclrxbufempty;
   logic          aclrxbuffull;
   logic          wr_drop_p;
`ifdef ACLRXBUF_LLID_EN
   logic [1:0]    wr_llid;
   logic [1:0]    rd_llid;
`endif

   modport master (
`ifdef ACLRXBUF_LLID_EN
      output wr_llid,
      input  rd_llid,
`endif
      output wr_start_p, wr_valid, wr_data, wr_commit_p, wr_discard_p,
      output rd_en, rd_pop,
      input  rd_data, rd_len, aclrxbufempty, aclrxbuffull, wr_drop_p
   );

   modport slave (
`ifdef ACLRXBUF_LLID_EN
      input  wr_llid,
      output rd_llid,
`endif
      input  wr_start_p, wr_valid, wr_data, wr_commit_p, wr_discard_p,
      input  rd_en, rd_pop,
      output rd_data, rd_len, aclrxbufempty, aclrxbuffull, wr_drop_p
   );
endinterface

// File: rtl/acl_rxbuf.sv
// Receive ACL-U payload buffer: NSLOT packet slots, committed on ARQ accept, read in order.
// Optional macro ACLRXBUF_LLID_EN stores a 2-bit LLID per committed slot.
module acl_rxbuf #(
   parameter int unsigned NSLOT = 2,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned LW    = 11
) (
   input  logic       clk_6M,
   input  logic       rstz,
   acl_rxbuf_if.slave bus
);
   localparam int unsigned PW = $clog2(NSLOT);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, FILL, DROP} wstate_e;

   wstate_e       state_q, state_d;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic [LW-1:0] wcnt_q, rcnt_q;
   logic [LW-1:0] len_q [NSLOT];
   logic [7:0]    mem [NSLOT*DEPTH];
   logic [7:0]    rd_data_q;
   logic [LW-1:0] head_len;
   logic          drop_q, drop_d;
   logic          do_store, do_commit;
   logic          empty, full, wr_at_end, rd_ok, pop_ok;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(NSLOT));
   assign wr_at_end = (wcnt_q == LW'(DEPTH));
   assign head_len  = empty ? '0 : len_q[rptr_q];
   assign rd_ok     = bus.rd_en && !empty && (rcnt_q < head_len);
   assign pop_ok    = bus.rd_pop && !empty;

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // A start pulse pre-empts whatever packet is in progress and re-runs the full check.
   always_comb begin
      state_d = state_q;
      if (bus.wr_start_p) begin
         state_d = full ? DROP : FILL;
      end else begin
         case (state_q)
            FILL: begin
               if (bus.wr_discard_p || bus.wr_commit_p) state_d = IDLE;
               else if (bus.wr_valid && wr_at_end)      state_d = DROP;
            end
            DROP: if (bus.wr_discard_p || bus.wr_commit_p) state_d = IDLE;
            default: ;
         endcase
      end
   end

   always_comb begin
      do_store  = 1'b0;
      do_commit = 1'b0;
      drop_d    = 1'b0;
      if (!bus.wr_start_p) begin
         case (state_q)
            FILL: begin
               if (!bus.wr_discard_p) begin
                  if (bus.wr_commit_p)                   do_commit = 1'b1;
                  else if (bus.wr_valid && !wr_at_end)   do_store  = 1'b1;
               end
            end
            DROP: drop_d = bus.wr_commit_p && !bus.wr_discard_p;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         wptr_q <= '0;
         wcnt_q <= '0;
         drop_q <= 1'b0;
         for (int unsigned i = 0; i < NSLOT; i++) len_q[i] <= '0;
      end else begin
         drop_q <= drop_d;
         if (bus.wr_start_p) wcnt_q <= '0;
         else if (do_store)  wcnt_q <= wcnt_q + 1'b1;
         if (do_commit) begin
            len_q[wptr_q] <= wcnt_q;
            wptr_q        <= wptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_6M) begin
      if (do_store) mem[{wptr_q, wcnt_q[AW-1:0]}] <= bus.wr_data;
   end

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         rptr_q    <= '0;
         rcnt_q    <= '0;
         rd_data_q <= '0;
      end else begin
         if (rd_ok) rd_data_q <= mem[{rptr_q, rcnt_q[AW-1:0]}];
         if (pop_ok) begin
            rptr_q <= rptr_q + 1'b1;
            rcnt_q <= '0;
         end else if (rd_ok) begin
            rcnt_q <= rcnt_q + 1'b1;
         end
      end
   end

   // Commit and pop in the same cycle cancel in the occupancy count.
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         count_q <= '0;
      end else begin
         case ({do_commit, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef ACLRXBUF_LLID_EN
   logic [1:0] llid_q [NSLOT];

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         for (int unsigned i = 0; i < NSLOT; i++) llid_q[i] <= '0;
      end else if (do_commit) begin
         llid_q[wptr_q] <= bus.wr_llid;
      end
   end

   assign bus.rd_llid = empty ? '0 : llid_q[rptr_q];
`endif

   assign bus.rd_data       = rd_data_q;
   assign bus.rd_len        = head_len;
   assign bus.aclrxbufempty = empty;
   assign bus.aclrxbuffull  = full;
   assign bus.wr_drop_p     = drop_q;

endmodule

// File: tb/tb_acl_rxbuf.sv
// Directed bench for acl_rxbuf: packet-queue model checked every cycle plus literal checkpoints.
module tb_acl_rxbuf;
   localparam int NSLOT = 2;
   localparam int DEPTH = 1024;
   localparam int LW    = 11;

   logic clk_6M = 1'b0;
   logic rstz;
   int   n_cmp = 0;
   int   n_bad = 0;

   acl_rxbuf_if #(.LW(LW)) bus ();

   acl_rxbuf #(.NSLOT(NSLOT), .DEPTH(DEPTH), .LW(LW)) dut (
      .clk_6M (clk_6M),
      .rstz   (rstz),
      .bus    (bus)
   );

   always #5 clk_6M = ~clk_6M;

   // Model: committed packets as a length queue over one flat byte stream.
   int         m_len[$];
   logic [7:0] m_bytes[$];
   logic [7:0] m_cur[$];
   logic [1:0] m_llid[$];
   bit         m_in, m_bad, m_drop, m_pop, m_full;
   int         m_ridx, m_hl;
   logic [7:0] m_rdata;

   always @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         m_len.delete(); m_bytes.delete(); m_cur.delete(); m_llid.delete();
         m_in = 0; m_bad = 0; m_drop = 0; m_ridx = 0; m_rdata = '0;
      end else begin
         m_hl   = (m_len.size() > 0) ? m_len[0] : 0;
         m_drop = 0;
         if (bus.rd_en && m_len.size() > 0 && m_ridx < m_hl) begin
            m_rdata = m_bytes[m_ridx];
            m_ridx++;
         end
         m_pop  = bus.rd_pop && (m_len.size() > 0);
         m_full = (m_len.size() == NSLOT);
         if (bus.wr_start_p) begin
            m_in = 1; m_bad = m_full; m_cur.delete();
         end else if (m_in) begin
            if (bus.wr_discard_p) begin
               m_in = 0;
            end else if (bus.wr_commit_p) begin
               m_in = 0;
               if (m_bad) m_drop = 1;
               else begin
                  m_len.push_back(m_cur.size());
                  foreach (m_cur[k]) m_bytes.push_back(m_cur[k]);
`ifdef ACLRXBUF_LLID_EN
                  m_llid.push_back(bus.wr_llid);
`else
                  m_llid.push_back(2'b00);
`endif
               end
            end else if (bus.wr_valid && !m_bad) begin
               if (m_cur.size() == DEPTH) m_bad = 1;
               else m_cur.push_back(bus.wr_data);
            end
         end
         if (m_pop) begin
            repeat (m_hl) void'(m_bytes.pop_front());
            void'(m_len.pop_front());
            void'(m_llid.pop_front());
            m_ridx = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_6M) begin
      chk("m_empty",  32'(bus.aclrxbufempty), 32'(m_len.size() == 0));
      chk("m_full",   32'(bus.aclrxbuffull),  32'(m_len.size() == NSLOT));
      chk("m_rd_len", 32'(bus.rd_len),        (m_len.size() > 0) ? 32'(m_len[0]) : 32'd0);
      chk("m_rd_data",32'(bus.rd_data),       32'(m_rdata));
      chk("m_drop",   32'(bus.wr_drop_p),     32'(m_drop));
`ifdef ACLRXBUF_LLID_EN
      chk("m_rd_llid",32'(bus.rd_llid),       (m_llid.size() > 0) ? 32'(m_llid[0]) : 32'd0);
`endif
   end

   task automatic cyc();
      @(negedge clk_6M);
   endtask

   task automatic wr_pkt(input logic [7:0] base, input int n);
      bus.wr_start_p = 1'b1; cyc(); bus.wr_start_p = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = base + 8'(i); cyc();
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic commit_p();
      bus.wr_commit_p = 1'b1; cyc(); bus.wr_commit_p = 1'b0;
   endtask

   task automatic discard_p();
      bus.wr_discard_p = 1'b1; cyc(); bus.wr_discard_p = 1'b0;
   endtask

   task automatic rd();
      bus.rd_en = 1'b1; cyc(); bus.rd_en = 1'b0;
   endtask

   task automatic pop();
      bus.rd_pop = 1'b1; cyc(); bus.rd_pop = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.wr_start_p = 0; bus.wr_valid = 0; bus.wr_data = '0; bus.wr_commit_p = 0;
      bus.wr_discard_p = 0; bus.rd_en = 0; bus.rd_pop = 0;
`ifdef ACLRXBUF_LLID_EN
      bus.wr_llid = '0;
`endif
      rstz = 1'b0;
      repeat (3) cyc();
      chk("rst_empty", 32'(bus.aclrxbufempty), 32'd1);
      chk("rst_full",  32'(bus.aclrxbuffull),  32'd0);
      chk("rst_len",   32'(bus.rd_len),        32'd0);
      chk("rst_data",  32'(bus.rd_data),       32'd0);
      chk("rst_drop",  32'(bus.wr_drop_p),     32'd0);
      rstz = 1'b1;
      cyc();

      // pass-through
      wr_pkt(8'h11, 5); commit_p();
      chk("pt_empty", 32'(bus.aclrxbufempty), 32'd0);
      chk("pt_len",   32'(bus.rd_len),        32'd5);
      for (int i = 0; i < 5; i++) begin
         rd(); chk("pt_data", 32'(bus.rd_data), 32'h11 + 32'(i));
      end
      pop();
      chk("pt_pop_empty", 32'(bus.aclrxbufempty), 32'd1);
      chk("pt_pop_len",   32'(bus.rd_len),        32'd0);

      // discard then reuse of the slot
      wr_pkt(8'h51, 3); discard_p();
      chk("dc_empty", 32'(bus.aclrxbufempty), 32'd1);
      wr_pkt(8'hA0, 2); commit_p();
      rd(); chk("dc_d0", 32'(bus.rd_data), 32'hA0);
      rd(); chk("dc_d1", 32'(bus.rd_data), 32'hA1);
      rd(); chk("dc_past_end", 32'(bus.rd_data), 32'hA1);
      pop();

      // full and drop on a third packet
      wr_pkt(8'h31, 3); commit_p();
      wr_pkt(8'h41, 2); commit_p();
      chk("fu_full", 32'(bus.aclrxbuffull), 32'd1);
      wr_pkt(8'h61, 4); commit_p();
      chk("fu_drop", 32'(bus.wr_drop_p), 32'd1);
      cyc();
      chk("fu_drop_end", 32'(bus.wr_drop_p),   32'd0);
      chk("fu_still",    32'(bus.aclrxbuffull), 32'd1);
      for (int i = 0; i < 3; i++) begin
         rd(); chk("fu_p1", 32'(bus.rd_data), 32'h31 + 32'(i));
      end
      pop();
      for (int i = 0; i < 2; i++) begin
         rd(); chk("fu_p2", 32'(bus.rd_data), 32'h41 + 32'(i));
      end
      pop();
      chk("fu_empty", 32'(bus.aclrxbufempty), 32'd1);

      // overflow: DEPTH+1 bytes
      wr_pkt(8'h00, DEPTH + 1); commit_p();
      chk("ov_drop",  32'(bus.wr_drop_p),     32'd1);
      chk("ov_empty", 32'(bus.aclrxbufempty), 32'd1);

      // zero-length commit
      bus.wr_start_p = 1'b1; cyc(); bus.wr_start_p = 1'b0;
      commit_p();
      chk("z_empty", 32'(bus.aclrxbufempty), 32'd0);
      chk("z_len",   32'(bus.rd_len),        32'd0);
      rd(); chk("z_hold", 32'(bus.rd_data), 32'h42);
      pop();

      // restart mid-packet, then commit+discard together
      wr_pkt(8'h70, 2); wr_pkt(8'h80, 1); commit_p();
      chk("rs_len", 32'(bus.rd_len), 32'd1);
      rd(); chk("rs_data", 32'(bus.rd_data), 32'h80);
      pop();
      wr_pkt(8'h90, 2);
      bus.wr_commit_p = 1'b1; bus.wr_discard_p = 1'b1; cyc();
      bus.wr_commit_p = 1'b0; bus.wr_discard_p = 1'b0;
      chk("cd_empty", 32'(bus.aclrxbufempty), 32'd1);

      // commit and pop in the same cycle
      wr_pkt(8'hB0, 2); commit_p();
      wr_pkt(8'hC0, 3);
      bus.wr_commit_p = 1'b1; bus.rd_pop = 1'b1; cyc();
      bus.wr_commit_p = 1'b0; bus.rd_pop = 1'b0;
      chk("sm_empty", 32'(bus.aclrxbufempty), 32'd0);
      chk("sm_full",  32'(bus.aclrxbuffull),  32'd0);
      chk("sm_len",   32'(bus.rd_len),        32'd3);
      for (int i = 0; i < 3; i++) begin
         rd(); chk("sm_data", 32'(bus.rd_data), 32'hC0 + 32'(i));
      end
      pop();

`ifdef ACLRXBUF_LLID_EN
      wr_pkt(8'hD0, 1);
      bus.wr_llid = 2'b10; commit_p(); bus.wr_llid = 2'b00;
      chk("ll_val", 32'(bus.rd_llid), 32'd2);
      pop();
      chk("ll_empty", 32'(bus.rd_llid), 32'd0);
`endif

      repeat (2) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
